// File: rtl/enc_dec_pkg.sv
// Code/one-hot types shared by the 8-to-3 encoder and the 3-to-8 decoder.
package enc_dec_pkg;

  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 8;

  typedef logic [IN_W-1:0]  code_t;
  typedef logic [OUT_W-1:0] onehot_t;

  function automatic onehot_t onehot_of(input code_t c);
    onehot_of    = '0;
    onehot_of[c] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides; in_ready is low while rst is high.
module sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign in_ready  = ~rst & (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoder3_8_stream.sv
// Streaming 3-to-8 decoder: buffered codes out as one-hot words, plus sticky seen_mask.
// Optional DEC_COUNT_EN adds dec_count, a wrapping count of delivered words.
module decoder3_8_stream
  import enc_dec_pkg::*;
#(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  code_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic [OUT_W-1:0] y_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             mask_clr,
`ifdef DEC_COUNT_EN
  output logic [CNT_W-1:0] dec_count,
`endif
  output logic [OUT_W-1:0] seen_mask
);

  logic            fifo_in_ready;
  logic [IN_W-1:0] head;
  logic [OUT_W-1:0] dec;
  logic            pop;

  sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (code_in),
    .in_valid  (in_valid & enable),
    .in_ready  (fifo_in_ready),
    .out_data  (head),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign in_ready = enable & fifo_in_ready;
  assign pop      = out_valid & out_ready;

  generate
    if (IN_W == enc_dec_pkg::IN_W) begin : g_pkg_dec
      assign dec = onehot_of(code_t'(head));
    end else begin : g_gen_dec
      assign dec = OUT_W'(1) << head;
    end
  endgenerate

  // Gate on out_valid so a stale or uninitialised head never leaks out.
  assign y_out = out_valid ? dec : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_mask <= '0;
    end else if (mask_clr) begin
      seen_mask <= pop ? y_out : '0;
    end else if (pop) begin
      seen_mask <= seen_mask | y_out;
    end
  end

`ifdef DEC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count <= '0;
    end else if (pop) begin
      dec_count <= dec_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder3_8_stream.sv
// Directed bench for decoder3_8_stream; the dec_count check runs when DEC_COUNT_EN is defined.
module tb_decoder3_8_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code_in;
  logic       in_valid;
  logic       in_ready;
  logic       enable;
  logic [7:0] y_out;
  logic       out_valid;
  logic       out_ready;
  logic       mask_clr;
  logic [7:0] seen_mask;
`ifdef DEC_COUNT_EN
  logic [7:0] dec_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  decoder3_8_stream #(
    .IN_W  (3),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enable    (enable),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mask_clr  (mask_clr),
`ifdef DEC_COUNT_EN
    .dec_count (dec_count),
`endif
    .seen_mask (seen_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    code_in  = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04; exp_seq[3] = 8'h08;

    rst = 1'b1; code_in = '0; in_valid = 1'b0; enable = 1'b1;
    out_ready = 1'b0; mask_clr = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_seen", seen_mask, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // single code 5 with sink ready
    out_ready = 1'b1;
    push(3'b101);
    check("c5_valid", out_valid, 1);
    check("c5_y", y_out, 8'h20);
    check("c5_seen_before_pop", seen_mask, 8'h00);
    step();
    check("c5_seen", seen_mask, 8'h20);
    check("c5_empty", out_valid, 0);

    // fill to full with sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(3'(i));
    check("full_in_ready", in_ready, 0);
    push(3'b100);
    check("full_head", y_out, 8'h01);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), y_out, {24'b0, exp_seq[i]});
      step();
    end
    check("drain_empty", out_valid, 0);
    check("drain_seen", seen_mask, 8'h2F);

    // count=1, simultaneous push and pop
    out_ready = 1'b0;
    push(3'b110);
    out_ready = 1'b1;
    code_in = 3'b111; in_valid = 1'b1;
    #1;
    check("pp_head", y_out, 8'h40);
    step();
    in_valid = 1'b0;
    check("pp_valid", out_valid, 1);
    check("pp_y", y_out, 8'h80);
    step();
    check("pp_empty", out_valid, 0);
    check("pp_seen", seen_mask, 8'hEF);

    // build seen_mask = F0, then clear together with pop of code 0
    mask_clr = 1'b1;
    step();
    mask_clr = 1'b0;
    check("clr_only", seen_mask, 8'h00);
    for (int i = 4; i < 8; i++) push(3'(i));
    step();
    check("seen_f0", seen_mask, 8'hF0);
    out_ready = 1'b0;
    push(3'b000);
    mask_clr = 1'b1; out_ready = 1'b1;
    step();
    mask_clr = 1'b0;
    check("clr_pop_seen", seen_mask, 8'h01);
    check("clr_pop_empty", out_valid, 0);

    // enable low with 2 entries queued
    out_ready = 1'b0;
    push(3'd2);
    push(3'd3);
    enable = 1'b0; code_in = 3'd1; in_valid = 1'b1;
    #1;
    check("dis_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    check("dis_y0", y_out, 8'h04);
    step();
    check("dis_y1", y_out, 8'h08);
    step();
    check("dis_empty", out_valid, 0);
    check("dis_seen", seen_mask, 8'h0D);
    enable = 1'b1;

    // reset with 3 entries queued
    out_ready = 1'b0;
    push(3'd1); push(3'd2); push(3'd3);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y_out, 0);
    check("mid_rst_seen", seen_mask, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    check("after_rst_valid", out_valid, 0);

`ifdef DEC_COUNT_EN
    check("cnt_reset", dec_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 258; i++) begin
      push(3'(i));
      if (i == 0) mask_clr = 1'b1;
      step();
      mask_clr = 1'b0;
    end
    check("cnt_258", dec_count, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
